// File: rtl/vga_pkg.sv
// Shared constants, FSM state type and size-code decoder for the VGA square overlay.
package vga_pkg;

    localparam int CD     = 12;
    localparam int HD     = 640;
    localparam int VD     = 480;
    localparam int HT     = 800;
    localparam int VT     = 525;
    localparam int STEP_W = 4;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_APPLY = 2'd1,
        S_STEP  = 2'd2
    } anim_state_t;

    // Highest set bit wins; an all-zero code switches the overlay off.
    function automatic logic [7:0] size_decode(input logic [3:0] code);
        logic [7:0] size;
        size = 8'd0;
        if (code[3])      size = 8'd128;
        else if (code[2]) size = 8'd64;
        else if (code[1]) size = 8'd32;
        else if (code[0]) size = 8'd16;
        return size;
    endfunction

endpackage

// File: rtl/bounce_axis.sv
// One axis of the square: position/direction registers, commit-time clamp and per-frame step with wall bounce.
module bounce_axis #(
    parameter int LIMIT  = 640,
    parameter int STEP_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_commit,
    input  logic [7:0]        i_new_size,
    input  logic              i_move,
    input  logic [STEP_W-1:0] i_step,
    input  logic [7:0]        i_size,
    output logic [10:0]       o_pos,
    output logic              o_hit
);

    localparam logic [11:0] LIM = 12'(LIMIT);

    logic [10:0] r_pos;
    logic        r_dir;
    logic [11:0] w_pos;
    logic [11:0] w_stp;
    logic [11:0] w_fwd;
    logic [11:0] w_grow;

    // All comparisons are done one bit wider than the position so nothing wraps.
    assign w_pos  = {1'b0, r_pos};
    assign w_stp  = 12'(i_step);
    assign w_fwd  = w_pos + w_stp + {4'b0, i_size};
    assign w_grow = w_pos + {4'b0, i_new_size};
    assign o_hit  = r_dir ? (w_pos <= w_stp) : (w_fwd >= LIM);
    assign o_pos  = r_pos;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pos <= 11'd0;
            r_dir <= 1'b0;
        end else if (i_commit) begin
            if (w_grow > LIM)
                r_pos <= 11'(LIM - {4'b0, i_new_size});
        end else if (i_move) begin
            if (o_hit) begin
                r_dir <= ~r_dir;
                r_pos <= r_dir ? 11'd0 : 11'(LIM - {4'b0, i_size});
            end else begin
                r_pos <= r_dir ? (r_pos - 11'(i_step)) : (r_pos + 11'(i_step));
            end
        end
    end

endmodule

// File: rtl/vga_square_anim_ctrl.sv
// Per-frame scheduler for the square overlay: host config handshake, vblank-time commit and bounce animation.
// Optional AUTO_COLOR_EN: each bounce rotates the colour one nibble left unless a config was committed that frame.
module vga_square_anim_ctrl #(
    parameter int CD     = vga_pkg::CD,
    parameter int HD     = vga_pkg::HD,
    parameter int VD     = vga_pkg::VD,
    parameter int STEP_W = vga_pkg::STEP_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_vblank_start,
    input  logic              i_pause,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [3:0]        i_cfg_size,
    input  logic [STEP_W-1:0] i_cfg_step,
    input  logic [CD-1:0]     i_cfg_color,
    output logic [10:0]       o_sq_x,
    output logic [10:0]       o_sq_y,
    output logic [7:0]        o_sq_size,
    output logic [CD-1:0]     o_sq_color,
    output logic              o_sq_on,
    output logic              o_bounce,
    output logic              o_busy
);

    import vga_pkg::*;

    anim_state_t       r_state;
    logic              r_pending;
    logic [3:0]        r_pend_size;
    logic [STEP_W-1:0] r_pend_step;
    logic [CD-1:0]     r_pend_color;
    logic [7:0]        r_size;
    logic [STEP_W-1:0] r_step;
    logic [CD-1:0]     r_color;
    logic              r_on;
    logic              r_bounce;
    logic              r_busy;
`ifdef AUTO_COLOR_EN
    logic              r_committed;
`endif

    logic       w_accept;
    logic       w_commit;
    logic       w_move;
    logic       w_hit_x;
    logic       w_hit_y;
    logic       w_bounce;
    logic [7:0] w_new_size;

    assign w_accept   = i_cfg_valid & ~r_pending;
    assign w_commit   = (r_state == S_APPLY) & r_pending;
    assign w_move     = (r_state == S_STEP) & ~i_pause & (r_size != 8'd0) & (r_step != '0);
    assign w_bounce   = w_move & (w_hit_x | w_hit_y);
    assign w_new_size = size_decode(r_pend_size);

    bounce_axis #(.LIMIT(HD), .STEP_W(STEP_W)) u_axis_x (
        .i_clk      (i_clk),
        .i_rst      (i_reset),
        .i_commit   (w_commit),
        .i_new_size (w_new_size),
        .i_move     (w_move),
        .i_step     (r_step),
        .i_size     (r_size),
        .o_pos      (o_sq_x),
        .o_hit      (w_hit_x)
    );

    bounce_axis #(.LIMIT(VD), .STEP_W(STEP_W)) u_axis_y (
        .i_clk      (i_clk),
        .i_rst      (i_reset),
        .i_commit   (w_commit),
        .i_new_size (w_new_size),
        .i_move     (w_move),
        .i_step     (r_step),
        .i_size     (r_size),
        .o_pos      (o_sq_y),
        .o_hit      (w_hit_y)
    );

    // Accept and commit are mutually exclusive because accept needs pending clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_WAIT;
            r_pending    <= 1'b0;
            r_pend_size  <= 4'd0;
            r_pend_step  <= '0;
            r_pend_color <= '0;
            r_size       <= 8'd0;
            r_step       <= STEP_W'(1);
            r_color      <= '0;
            r_on         <= 1'b0;
            r_bounce     <= 1'b0;
            r_busy       <= 1'b0;
`ifdef AUTO_COLOR_EN
            r_committed  <= 1'b0;
`endif
        end else begin
            r_bounce <= 1'b0;
            if (w_accept) begin
                r_pending    <= 1'b1;
                r_pend_size  <= i_cfg_size;
                r_pend_step  <= i_cfg_step;
                r_pend_color <= i_cfg_color;
            end
            case (r_state)
                S_WAIT: begin
                    if (i_vblank_start) begin
                        r_state <= S_APPLY;
                        r_busy  <= 1'b1;
                    end
                end
                S_APPLY: begin
                    r_state <= S_STEP;
                    r_busy  <= 1'b1;
`ifdef AUTO_COLOR_EN
                    r_committed <= r_pending;
`endif
                    if (r_pending) begin
                        r_pending <= 1'b0;
                        r_size    <= w_new_size;
                        r_on      <= (w_new_size != 8'd0);
                        r_step    <= r_pend_step;
                        r_color   <= r_pend_color;
                    end
                end
                S_STEP: begin
                    r_state  <= S_WAIT;
                    r_busy   <= 1'b0;
                    r_bounce <= w_bounce;
`ifdef AUTO_COLOR_EN
                    if (w_bounce && !r_committed)
                        r_color <= {r_color[CD-5:0], r_color[CD-1:CD-4]};
`endif
                end
                default: begin
                    r_state <= S_WAIT;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_cfg_ready = ~r_pending;
    assign o_sq_size   = r_size;
    assign o_sq_color  = r_color;
    assign o_sq_on     = r_on;
    assign o_bounce    = r_bounce;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_vga_square_anim_ctrl.sv
// Self-checking bench for vga_square_anim_ctrl: hand sequences plus a per-frame vector table.
module tb_vga_square_anim_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        vblankStart;
   logic        pause;
   logic        cfgValid;
   logic        cfgReady;
   logic [3:0]  cfgSize;
   logic [3:0]  cfgStep;
   logic [11:0] cfgColor;
   logic [10:0] sqX;
   logic [10:0] sqY;
   logic [7:0]  sqSize;
   logic [11:0] sqColor;
   logic        sqOn;
   logic        bounce;
   logic        busy;

   int totalChecks = 0;
   int passedChecks = 0;

   always #5 clk = ~clk;

   vga_square_anim_ctrl dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_vblank_start (vblankStart),
      .i_pause        (pause),
      .i_cfg_valid    (cfgValid),
      .o_cfg_ready    (cfgReady),
      .i_cfg_size     (cfgSize),
      .i_cfg_step     (cfgStep),
      .i_cfg_color    (cfgColor),
      .o_sq_x         (sqX),
      .o_sq_y         (sqY),
      .o_sq_size      (sqSize),
      .o_sq_color     (sqColor),
      .o_sq_on        (sqOn),
      .o_bounce       (bounce),
      .o_busy         (busy)
   );

   typedef struct {
      logic        doCfg;
      logic [3:0]  size;
      logic [3:0]  step;
      logic [11:0] color;
      logic        pause;
      int          frames;
      logic [10:0] expX;
      logic [10:0] expY;
      logic [7:0]  expSize;
      logic [11:0] expColor;
      logic        expBounce;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      totalChecks++;
      if (actual === expected) passedChecks++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   // Submits one config; called at a negedge, returns at a negedge with valid dropped.
   task automatic applyStimulus(input logic [3:0] s, input logic [3:0] st, input logic [11:0] c);
      int n;
      logic accepted;
      n = 0;
      accepted = 1'b0;
      cfgValid = 1'b1;
      cfgSize = s;
      cfgStep = st;
      cfgColor = c;
      while (!accepted && n < 20) begin
         if (cfgReady) accepted = 1'b1;
         @(negedge clk);
         n++;
      end
      cfgValid = 1'b0;
      checkOutput("cfg_accept", 32'(accepted), 32'd1);
   endtask

   // One full frame: vblank pulse, APPLY, STEP, then one cycle for the bounce pulse to clear.
   task automatic runFrame(output logic pulse, output logic after);
      vblankStart = 1'b1;
      @(negedge clk);
      vblankStart = 1'b0;
      @(negedge clk);
      @(negedge clk);
      pulse = bounce;
      @(negedge clk);
      after = bounce;
   endtask

   initial begin
      logic pulse;
      logic after;
      logic [11:0] rot1;
      logic [11:0] rot2;

`ifdef AUTO_COLOR_EN
      rot1 = 12'h00F;
      rot2 = 12'hA50;
`else
      rot1 = 12'hF00;
      rot2 = 12'h0A5;
`endif
      vecs[0]  = '{1'b0, 4'b0000, 4'd0,  12'h000, 1'b0, 114, 11'd460, 11'd460, 8'd16,  12'hF00, 1'b0};
      vecs[1]  = '{1'b1, 4'b1000, 4'd0,  12'hF00, 1'b0, 1,   11'd460, 11'd352, 8'd128, 12'hF00, 1'b0};
      vecs[2]  = '{1'b1, 4'b0001, 4'd4,  12'hF00, 1'b0, 1,   11'd464, 11'd356, 8'd16,  12'hF00, 1'b0};
      vecs[3]  = '{1'b0, 4'b0000, 4'd0,  12'h000, 1'b0, 26,  11'd568, 11'd460, 8'd16,  12'hF00, 1'b0};
      vecs[4]  = '{1'b1, 4'b1000, 4'd0,  12'hF00, 1'b0, 1,   11'd512, 11'd352, 8'd128, 12'hF00, 1'b0};
      vecs[5]  = '{1'b1, 4'b0001, 4'd4,  12'hF00, 1'b0, 1,   11'd516, 11'd356, 8'd16,  12'hF00, 1'b0};
      vecs[6]  = '{1'b0, 4'b0000, 4'd0,  12'h000, 1'b0, 26,  11'd620, 11'd460, 8'd16,  12'hF00, 1'b0};
      vecs[7]  = '{1'b0, 4'b0000, 4'd0,  12'h000, 1'b0, 1,   11'd624, 11'd464, 8'd16,  rot1,    1'b1};
      vecs[8]  = '{1'b0, 4'b0000, 4'd0,  12'h000, 1'b0, 1,   11'd620, 11'd460, 8'd16,  rot1,    1'b0};
      vecs[9]  = '{1'b1, 4'b0100, 4'd4,  12'h0F0, 1'b1, 3,   11'd576, 11'd416, 8'd64,  12'h0F0, 1'b0};
      vecs[10] = '{1'b0, 4'b0000, 4'd0,  12'h000, 1'b0, 1,   11'd572, 11'd412, 8'd64,  12'h0F0, 1'b0};
      vecs[11] = '{1'b1, 4'b0000, 4'd4,  12'h00F, 1'b0, 2,   11'd572, 11'd412, 8'd0,   12'h00F, 1'b0};
      vecs[12] = '{1'b1, 4'b0011, 4'd15, 12'h0A5, 1'b0, 1,   11'd557, 11'd397, 8'd32,  12'h0A5, 1'b0};
      vecs[13] = '{1'b1, 4'b0110, 4'd15, 12'h0A5, 1'b0, 26,  11'd167, 11'd7,   8'd64,  12'h0A5, 1'b0};
      vecs[14] = '{1'b0, 4'b0000, 4'd0,  12'h000, 1'b0, 1,   11'd152, 11'd0,   8'd64,  rot2,    1'b1};
      vecs[15] = '{1'b0, 4'b0000, 4'd0,  12'h000, 1'b0, 1,   11'd137, 11'd15,  8'd64,  rot2,    1'b0};

      reset = 1'b1;
      vblankStart = 1'b0;
      pause = 1'b0;
      cfgValid = 1'b0;
      cfgSize = 4'd0;
      cfgStep = 4'd0;
      cfgColor = 12'h000;
      repeat (3) @(negedge clk);
      checkOutput("rst_x", 32'(sqX), 32'd0);
      checkOutput("rst_y", 32'(sqY), 32'd0);
      checkOutput("rst_size", 32'(sqSize), 32'd0);
      checkOutput("rst_on", 32'(sqOn), 32'd0);
      checkOutput("rst_color", 32'(sqColor), 32'd0);
      checkOutput("rst_bounce", 32'(bounce), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_ready", 32'(cfgReady), 32'd1);
      reset = 1'b0;
      @(negedge clk);

      // First config and first frame, step by step.
      applyStimulus(4'b0001, 4'd4, 12'hF00);
      checkOutput("t1_ready_drop", 32'(cfgReady), 32'd0);
      vblankStart = 1'b1;
      @(negedge clk);
      vblankStart = 1'b0;
      checkOutput("t1_busy_apply", 32'(busy), 32'd1);
      checkOutput("t1_ready_apply", 32'(cfgReady), 32'd0);
      @(negedge clk);
      checkOutput("t1_ready_back", 32'(cfgReady), 32'd1);
      checkOutput("t1_size_commit", 32'(sqSize), 32'd16);
      checkOutput("t1_x_commit", 32'(sqX), 32'd0);
      checkOutput("t1_busy_step", 32'(busy), 32'd1);
      @(negedge clk);
      checkOutput("t1_bounce", 32'(bounce), 32'd0);
      checkOutput("t1_busy_done", 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput("t1_x", 32'(sqX), 32'd4);
      checkOutput("t1_y", 32'(sqY), 32'd4);
      checkOutput("t1_size", 32'(sqSize), 32'd16);
      checkOutput("t1_on", 32'(sqOn), 32'd1);
      checkOutput("t1_color", 32'(sqColor), 32'hF00);

      for (int i = 0; i < NV; i++) begin
         pause = vecs[i].pause;
         if (vecs[i].doCfg) applyStimulus(vecs[i].size, vecs[i].step, vecs[i].color);
         pulse = 1'b0;
         after = 1'b0;
         for (int f = 0; f < vecs[i].frames; f++) runFrame(pulse, after);
         checkOutput($sformatf("row%0d_x", i), 32'(sqX), 32'(vecs[i].expX));
         checkOutput($sformatf("row%0d_y", i), 32'(sqY), 32'(vecs[i].expY));
         checkOutput($sformatf("row%0d_size", i), 32'(sqSize), 32'(vecs[i].expSize));
         checkOutput($sformatf("row%0d_on", i), 32'(sqOn), 32'(vecs[i].expSize != 8'd0));
         checkOutput($sformatf("row%0d_color", i), 32'(sqColor), 32'(vecs[i].expColor));
         checkOutput($sformatf("row%0d_bounce", i), 32'(pulse), 32'(vecs[i].expBounce));
         checkOutput($sformatf("row%0d_bounce_clear", i), 32'(after), 32'd0);
         checkOutput($sformatf("row%0d_busy", i), 32'(busy), 32'd0);
      end
      pause = 1'b0;

      // Back-to-back configs: the second one is held until the first commits.
      applyStimulus(4'b0001, 4'd2, 12'h123);
      cfgValid = 1'b1;
      cfgSize = 4'b0010;
      cfgStep = 4'd3;
      cfgColor = 12'h456;
      checkOutput("b2b_hold", 32'(cfgReady), 32'd0);
      vblankStart = 1'b1;
      @(negedge clk);
      vblankStart = 1'b0;
      checkOutput("b2b_ready_apply", 32'(cfgReady), 32'd0);
      @(negedge clk);
      checkOutput("b2b_ready_step", 32'(cfgReady), 32'd1);
      checkOutput("b2b_size1", 32'(sqSize), 32'd16);
      checkOutput("b2b_color1", 32'(sqColor), 32'h123);
      @(negedge clk);
      cfgValid = 1'b0;
      checkOutput("b2b_second_latched", 32'(cfgReady), 32'd0);
      checkOutput("b2b_x1", 32'(sqX), 32'd135);
      checkOutput("b2b_y1", 32'(sqY), 32'd17);
      @(negedge clk);
      // vblank held through APPLY and STEP must not restart the sequence.
      vblankStart = 1'b1;
      repeat (3) @(negedge clk);
      vblankStart = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("b2b_busy", 32'(busy), 32'd0);
      checkOutput("b2b_x2", 32'(sqX), 32'd132);
      checkOutput("b2b_y2", 32'(sqY), 32'd20);
      checkOutput("b2b_size2", 32'(sqSize), 32'd32);
      checkOutput("b2b_color2", 32'(sqColor), 32'h456);
      checkOutput("b2b_ready_end", 32'(cfgReady), 32'd1);

      // Reset while in S_STEP.
      vblankStart = 1'b1;
      @(negedge clk);
      vblankStart = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("rs_x", 32'(sqX), 32'd0);
      checkOutput("rs_y", 32'(sqY), 32'd0);
      checkOutput("rs_size", 32'(sqSize), 32'd0);
      checkOutput("rs_on", 32'(sqOn), 32'd0);
      checkOutput("rs_color", 32'(sqColor), 32'd0);
      checkOutput("rs_busy", 32'(busy), 32'd0);
      checkOutput("rs_ready", 32'(cfgReady), 32'd1);
      @(negedge clk);
      checkOutput("rs_no_bounce", 32'(bounce), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Reset discards a pending config.
      applyStimulus(4'b0001, 4'd4, 12'hFFF);
      checkOutput("rp_pending", 32'(cfgReady), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("rp_ready", 32'(cfgReady), 32'd1);
      runFrame(pulse, after);
      checkOutput("rp_size", 32'(sqSize), 32'd0);
      checkOutput("rp_on", 32'(sqOn), 32'd0);
      checkOutput("rp_color", 32'(sqColor), 32'd0);
      checkOutput("rp_x", 32'(sqX), 32'd0);

      $display("%0d/%0d checks passed", passedChecks, totalChecks);
      $finish;
   end

endmodule
